// File: rtl/chien_ctrl_if.sv
// Bundles the Chien search controller's request, locator, cell and result signals.
interface chien_ctrl_if;
  localparam int unsigned SW = 4;
  localparam int unsigned DW = 2;

  logic          start;
  logic [SW-1:0] lambda_0;
  logic [DW-1:0] lambda_deg;
  logic [SW-1:0] chien_1;
  logic [SW-1:0] chien_2;
  logic          control;
  logic          busy;
  logic          err_valid;
  logic [SW-1:0] err_loc;
  logic [DW-1:0] root_cnt;
  logic          done;
  logic          fail;

  modport master (
    output start, lambda_0, lambda_deg, chien_1, chien_2,
    input  control, busy, err_valid, err_loc, root_cnt, done, fail
  );

  modport slave (
    input  start, lambda_0, lambda_deg, chien_1, chien_2,
    output control, busy, err_valid, err_loc, root_cnt, done, fail
  );
endinterface

// File: rtl/chien_ctrl.sv
// Chien search sequencer for a GF(16) RS(15) decoder: drives the Chien cells,
// flags locator roots as error positions and judges decoding success.
module chien_ctrl #(
  parameter int unsigned NSYM = 15
) (
  input  logic         clk,
  input  logic         reset,
  chien_ctrl_if.slave  bus
);
  localparam int unsigned SW = 4;
  localparam int unsigned DW = 2;
  localparam int unsigned STW = 2;

  localparam logic [STW-1:0] IDLE = 2'd0;
  localparam logic [STW-1:0] LOAD = 2'd1;
  localparam logic [STW-1:0] SCAN = 2'd2;
  localparam logic [STW-1:0] FIN  = 2'd3;

  localparam logic [SW-1:0] LAST    = SW'(NSYM);
  localparam logic [DW-1:0] CNT_MAX = DW'(3);

  logic [STW-1:0] state, state_nxt;
  logic [SW-1:0]  idx, idx_nxt;
  logic [SW-1:0]  lam0, lam0_nxt;
  logic [DW-1:0]  deg, deg_nxt;
  logic           control, control_nxt;
  logic           busy, busy_nxt;
  logic           err_valid, err_valid_nxt;
  logic [SW-1:0]  err_loc, err_loc_nxt;
  logic [DW-1:0]  root_cnt, root_cnt_nxt;
  logic           done, done_nxt;
  logic           fail, fail_nxt;
  logic           hit_c;

  // Locator evaluates to zero at alpha^idx: GF(16) sum of all terms.
  assign hit_c = (state == SCAN) && ((lam0 ^ bus.chien_1 ^ bus.chien_2) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      lam0      <= '0;
      deg       <= '0;
      control   <= 1'b0;
      busy      <= 1'b0;
      err_valid <= 1'b0;
      err_loc   <= '0;
      root_cnt  <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      lam0      <= lam0_nxt;
      deg       <= deg_nxt;
      control   <= control_nxt;
      busy      <= busy_nxt;
      err_valid <= err_valid_nxt;
      err_loc   <= err_loc_nxt;
      root_cnt  <= root_cnt_nxt;
      done      <= done_nxt;
      fail      <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    lam0_nxt      = lam0;
    deg_nxt       = deg;
    control_nxt   = 1'b0;
    busy_nxt      = busy;
    err_valid_nxt = 1'b0;
    err_loc_nxt   = err_loc;
    root_cnt_nxt  = root_cnt;
    done_nxt      = 1'b0;
    fail_nxt      = fail;

    // Root at alpha^i maps to error position -i mod 15.
    if (hit_c) begin
      err_valid_nxt = 1'b1;
      err_loc_nxt   = (idx == LAST) ? '0 : SW'(LAST - idx);
      root_cnt_nxt  = (root_cnt == CNT_MAX) ? CNT_MAX : DW'(root_cnt + DW'(1));
    end

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt    = LOAD;
          idx_nxt      = '0;
          lam0_nxt     = bus.lambda_0;
          deg_nxt      = bus.lambda_deg;
          control_nxt  = 1'b1;
          busy_nxt     = 1'b1;
          root_cnt_nxt = '0;
          fail_nxt     = 1'b0;
        end
      end
      LOAD: begin
        state_nxt = SCAN;
        idx_nxt   = SW'(1);
      end
      SCAN: begin
        // Verdict includes a root found in this final cycle.
        if (idx == LAST) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
          fail_nxt  = (root_cnt_nxt != deg) || (deg == CNT_MAX);
        end else begin
          idx_nxt = SW'(idx + SW'(1));
        end
      end
      FIN: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.control   = control;
  assign bus.busy      = busy;
  assign bus.err_valid = err_valid;
  assign bus.err_loc   = err_loc;
  assign bus.root_cnt  = root_cnt;
  assign bus.done      = done;
  assign bus.fail      = fail;
endmodule
